// File: rtl/fractal_sync_mp_rf_ctrl.sv
// rtl/fractal_sync_mp_rf_ctrl.sv - request front-end for the fractal sync multi-port RF
package fractal_sync_pkg;
  localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_mp_rf_ctrl #(
  parameter  int unsigned N_PORTS   = 2,
  parameter  int unsigned N_REGS    = 2,
  parameter  int unsigned IDX_WIDTH = 1,
  localparam int unsigned SD_WIDTH  = fractal_sync_pkg::SD_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i    [N_PORTS],
  output logic                 req_ready_o    [N_PORTS],
  input  logic                 req_set_i      [N_PORTS],
  input  logic [IDX_WIDTH-1:0] req_idx_i      [N_PORTS],
  input  logic [SD_WIDTH-1:0]  req_sd_i       [N_PORTS],
  output logic                 rsp_valid_o    [N_PORTS],
  input  logic                 rsp_ready_i    [N_PORTS],
  output logic [IDX_WIDTH-1:0] rsp_idx_o      [N_PORTS],
  output logic [SD_WIDTH-1:0]  rsp_sd_o       [N_PORTS],
  output logic                 rf_check_o     [N_PORTS],
  output logic                 rf_set_o       [N_PORTS],
  output logic                 rf_idx_valid_o [N_PORTS],
  output logic [IDX_WIDTH-1:0] rf_idx_o       [N_PORTS],
  output logic [SD_WIDTH-1:0]  rf_sd_o        [N_PORTS],
  input  logic                 rf_present_i   [N_PORTS],
  input  logic [SD_WIDTH-1:0]  rf_sd_i        [N_PORTS]
);

  localparam int unsigned REG_IDX_WIDTH = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned RR_WIDTH      = $clog2(N_PORTS);

  if (N_PORTS < 2) begin : g_ports_check
    $fatal(1, "fractal_sync_mp_rf_ctrl: N_PORTS must be at least 2");
  end
  if ((2 ** IDX_WIDTH) < N_REGS) begin : g_idx_check
    $fatal(1, "fractal_sync_mp_rf_ctrl: IDX_WIDTH too narrow for N_REGS");
  end

  typedef enum logic {EMPTY, PEND} buf_state_e;

  buf_state_e           state_q     [N_PORTS];
  logic                 set_q       [N_PORTS];
  logic [IDX_WIDTH-1:0] idx_q       [N_PORTS];
  logic [SD_WIDTH-1:0]  sd_q        [N_PORTS];
  logic                 rsp_valid_q [N_PORTS];
  logic [IDX_WIDTH-1:0] rsp_idx_q   [N_PORTS];
  logic [SD_WIDTH-1:0]  rsp_sd_q    [N_PORTS];
  logic [RR_WIDTH-1:0]  rr_q;

  logic eligible  [N_PORTS];
  logic issue     [N_PORTS];
  logic req_ready [N_PORTS];
  logic conflict;

  // Distance of a port from the round-robin pointer; smaller wins a conflict.
  function automatic int unsigned rr_pos(input int unsigned p, input logic [RR_WIDTH-1:0] rr);
    return (p + N_PORTS - 32'(rr)) % N_PORTS;
  endfunction

  // A check is held back while its response slot cannot accept a completion.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      eligible[p] = (state_q[p] == PEND) &&
                    (set_q[p] || !rsp_valid_q[p] || rsp_ready_i[p]);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      issue[p] = eligible[p];
      for (int unsigned q = 0; q < N_PORTS; q++) begin
        if (q != p && eligible[p] && eligible[q] &&
            idx_q[p][REG_IDX_WIDTH-1:0] == idx_q[q][REG_IDX_WIDTH-1:0]) begin
          conflict = 1'b1;
          if (rr_pos(q, rr_q) < rr_pos(p, rr_q)) issue[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      req_ready[p]      = (state_q[p] == EMPTY) || issue[p];
      req_ready_o[p]    = req_ready[p];
      rf_idx_valid_o[p] = issue[p];
      rf_check_o[p]     = issue[p] && !set_q[p];
      rf_set_o[p]       = issue[p] && set_q[p];
      rf_idx_o[p]       = (state_q[p] == PEND) ? idx_q[p] : '0;
      rf_sd_o[p]        = (state_q[p] == PEND) ? sd_q[p] : '0;
      rsp_valid_o[p]    = rsp_valid_q[p];
      rsp_idx_o[p]      = rsp_idx_q[p];
      rsp_sd_o[p]       = rsp_sd_q[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p]     <= EMPTY;
        set_q[p]       <= 1'b0;
        idx_q[p]       <= '0;
        sd_q[p]        <= '0;
        rsp_valid_q[p] <= 1'b0;
        rsp_idx_q[p]   <= '0;
        rsp_sd_q[p]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (req_valid_i[p] && req_ready[p]) begin
          state_q[p] <= PEND;
          set_q[p]   <= req_set_i[p];
          idx_q[p]   <= req_idx_i[p];
          sd_q[p]    <= req_sd_i[p];
        end else if (issue[p]) begin
          state_q[p] <= EMPTY;
        end
        // A completing check overrides a same-cycle drain of the slot.
        if (issue[p] && !set_q[p] && rf_present_i[p]) begin
          rsp_valid_q[p] <= 1'b1;
          rsp_idx_q[p]   <= idx_q[p];
          rsp_sd_q[p]    <= rf_sd_i[p] | sd_q[p];
        end else if (rsp_valid_q[p] && rsp_ready_i[p]) begin
          rsp_valid_q[p] <= 1'b0;
        end
      end
      if (conflict) begin
        rr_q <= (rr_q == RR_WIDTH'(N_PORTS - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fractal_sync_mp_rf_ctrl.sv
// tb/tb_fractal_sync_mp_rf_ctrl.sv - directed self-checking bench for fractal_sync_mp_rf_ctrl
module tb_fractal_sync_mp_rf_ctrl;
  localparam int unsigned NP = 2;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned SW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid    [NP];
  logic          req_ready    [NP];
  logic          req_set      [NP];
  logic [IW-1:0] req_idx      [NP];
  logic [SW-1:0] req_sd       [NP];
  logic          rsp_valid    [NP];
  logic          rsp_ready    [NP];
  logic [IW-1:0] rsp_idx      [NP];
  logic [SW-1:0] rsp_sd       [NP];
  logic          rf_check     [NP];
  logic          rf_set       [NP];
  logic          rf_idx_valid [NP];
  logic [IW-1:0] rf_idx       [NP];
  logic [SW-1:0] rf_sd        [NP];
  logic          rf_present   [NP];
  logic [SW-1:0] rf_sd_rd     [NP];

  logic          reg_pres [NR];
  logic [SW-1:0] reg_sd   [NR];

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  fractal_sync_mp_rf_ctrl #(.N_PORTS(NP), .N_REGS(NR), .IDX_WIDTH(IW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_set_i      (req_set),
    .req_idx_i      (req_idx),
    .req_sd_i       (req_sd),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_idx_o      (rsp_idx),
    .rsp_sd_o       (rsp_sd),
    .rf_check_o     (rf_check),
    .rf_set_o       (rf_set),
    .rf_idx_valid_o (rf_idx_valid),
    .rf_idx_o       (rf_idx),
    .rf_sd_o        (rf_sd),
    .rf_present_i   (rf_present),
    .rf_sd_i        (rf_sd_rd)
  );

  // Behavioural register file: check toggles present, set forces present and merges sd.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rf_present[p] = reg_pres[rf_idx[p]];
      rf_sd_rd[p]   = reg_sd[rf_idx[p]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR; r++) begin
        reg_pres[r] <= 1'b0;
        reg_sd[r]   <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rf_idx_valid[p]) begin
          if (rf_set[p]) begin
            reg_pres[rf_idx[p]] <= 1'b1;
            reg_sd[rf_idx[p]]   <= reg_sd[rf_idx[p]] | rf_sd[p];
          end else if (reg_pres[rf_idx[p]]) begin
            reg_pres[rf_idx[p]] <= 1'b0;
            reg_sd[rf_idx[p]]   <= '0;
          end else begin
            reg_pres[rf_idx[p]] <= 1'b1;
            reg_sd[rf_idx[p]]   <= rf_sd[p];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic v, input logic s, input logic [IW-1:0] i,
                     input logic [SW-1:0] d);
    req_valid[p] = v;
    req_set[p]   = s;
    req_idx[p]   = i;
    req_sd[p]    = d;
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int p = 0; p < NP; p++) begin
      drv(p, 1'b0, 1'b0, '0, '0);
      rsp_ready[p] = 1'b1;
    end

    // Reset values
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("rst_req_ready0", req_ready[0], 1'b1);
    chk("rst_req_ready1", req_ready[1], 1'b1);
    chk("rst_rsp_valid0", rsp_valid[0], 1'b0);
    chk("rst_rsp_idx0", rsp_idx[0], 0);
    chk("rst_rsp_sd1", rsp_sd[1], 0);
    chk("rst_rf_idx_valid0", rf_idx_valid[0], 1'b0);
    chk("rst_rf_idx0", rf_idx[0], 0);
    chk("rst_rf_sd0", rf_sd[0], 0);
    chk("rst_rr", dut.rr_q, 0);

    // Reset while port 0 is pending
    @(negedge clk_i);
    rst_ni = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b1, 2'b01);
    #1 chk("mid_accept_ready0", req_ready[0], 1'b1);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1 chk("mid_pend_strobe0", rf_idx_valid[0], 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_strobe0", rf_idx_valid[0], 1'b0);
    chk("mid_rst_ready0", req_ready[0], 1'b1);
    chk("mid_rst_rsp_valid0", rsp_valid[0], 1'b0);
    chk("mid_rst_rf_idx0", rf_idx[0], 0);
    chk("mid_rst_rr", dut.rr_q, 0);

    // Barrier pair on register 1
    @(negedge clk_i);
    rst_ni = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b1, 2'b01);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("bp_p0_idx_valid", rf_idx_valid[0], 1'b1);
    chk("bp_p0_check", rf_check[0], 1'b1);
    chk("bp_p0_set", rf_set[0], 1'b0);
    chk("bp_p0_rf_idx", rf_idx[0], 1);
    chk("bp_p0_rf_sd", rf_sd[0], 2'b01);
    @(negedge clk_i);
    drv(1, 1'b1, 1'b0, 1'b1, 2'b10);
    #1;
    chk("bp_p0_no_rsp", rsp_valid[0], 1'b0);
    chk("bp_p0_idle", rf_idx_valid[0], 1'b0);
    @(negedge clk_i);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("bp_p1_idx_valid", rf_idx_valid[1], 1'b1);
    chk("bp_p1_rsp_not_yet", rsp_valid[1], 1'b0);
    @(negedge clk_i); #1;
    chk("bp_p1_rsp_valid", rsp_valid[1], 1'b1);
    chk("bp_p1_rsp_idx", rsp_idx[1], 1);
    chk("bp_p1_rsp_sd", rsp_sd[1], 2'b11);
    chk("bp_p0_rsp_quiet", rsp_valid[0], 1'b0);

    // Same-cycle conflict on register 0, rr at 0
    @(negedge clk_i);
    drv(0, 1'b1, 1'b0, 1'b0, 2'b01);
    drv(1, 1'b1, 1'b0, 1'b0, 2'b10);
    #1 chk("cf_p1_rsp_drained", rsp_valid[1], 1'b0);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("cf1_p0_wins", rf_idx_valid[0], 1'b1);
    chk("cf1_p1_waits", rf_idx_valid[1], 1'b0);
    chk("cf1_p1_not_ready", req_ready[1], 1'b0);
    chk("cf1_rr_before", dut.rr_q, 0);
    @(negedge clk_i); #1;
    chk("cf1_rr_after", dut.rr_q, 1);
    chk("cf1_p1_issues", rf_idx_valid[1], 1'b1);
    chk("cf1_p0_idle", rf_idx_valid[0], 1'b0);
    chk("cf1_p0_no_rsp", rsp_valid[0], 1'b0);
    @(negedge clk_i);
    drv(0, 1'b1, 1'b0, 1'b0, 2'b01);
    drv(1, 1'b1, 1'b0, 1'b0, 2'b10);
    #1;
    chk("cf1_p1_rsp_valid", rsp_valid[1], 1'b1);
    chk("cf1_p1_rsp_idx", rsp_idx[1], 0);
    chk("cf1_p1_rsp_sd", rsp_sd[1], 2'b11);
    chk("cf1_rr_hold", dut.rr_q, 1);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("cf2_p1_wins", rf_idx_valid[1], 1'b1);
    chk("cf2_p0_waits", rf_idx_valid[0], 1'b0);
    @(negedge clk_i); #1;
    chk("cf2_rr_wrap", dut.rr_q, 0);
    chk("cf2_p0_issues", rf_idx_valid[0], 1'b1);
    chk("cf2_p1_no_rsp", rsp_valid[1], 1'b0);
    @(negedge clk_i);
    rsp_ready[0] = 1'b0;
    drv(1, 1'b1, 1'b0, 1'b1, 2'b10);
    #1;
    chk("cf2_p0_rsp_valid", rsp_valid[0], 1'b1);
    chk("cf2_p0_rsp_sd", rsp_sd[0], 2'b11);

    // Back-pressure on port 0 response slot
    @(negedge clk_i);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(0, 1'b1, 1'b0, 1'b1, 2'b01);
    #1 chk("bk_p1_first_arrival", rf_idx_valid[1], 1'b1);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("bk_p0_blocked", rf_idx_valid[0], 1'b0);
    chk("bk_p0_not_ready", req_ready[0], 1'b0);
    chk("bk_rsp_hold_valid", rsp_valid[0], 1'b1);
    chk("bk_rsp_hold_idx", rsp_idx[0], 0);
    chk("bk_rsp_hold_sd", rsp_sd[0], 2'b11);
    @(negedge clk_i);
    #1 chk("bk_p0_still_blocked", req_ready[0], 1'b0);
    rsp_ready[0] = 1'b1;
    #1;
    chk("bk_p0_issue", rf_idx_valid[0], 1'b1);
    chk("bk_p0_ready", req_ready[0], 1'b1);
    @(negedge clk_i); #1;
    chk("bk_new_rsp_valid", rsp_valid[0], 1'b1);
    chk("bk_new_rsp_idx", rsp_idx[0], 1);
    chk("bk_new_rsp_sd", rsp_sd[0], 2'b11);

    // Set on a present register, then a completing check
    drv(1, 1'b1, 1'b0, 1'b1, 2'b10);
    @(negedge clk_i);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(0, 1'b1, 1'b1, 1'b1, 2'b01);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("set_strobe", rf_set[0], 1'b1);
    chk("set_no_check", rf_check[0], 1'b0);
    chk("set_idx_valid", rf_idx_valid[0], 1'b1);
    @(negedge clk_i);
    drv(1, 1'b1, 1'b0, 1'b1, 2'b10);
    #1 chk("set_no_rsp", rsp_valid[0], 1'b0);
    @(negedge clk_i);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk_i); #1;
    chk("set_chk_rsp_valid", rsp_valid[1], 1'b1);
    chk("set_chk_rsp_idx", rsp_idx[1], 1);
    chk("set_chk_rsp_sd", rsp_sd[1], 2'b11);

    // Parallel non-conflicting issue
    drv(0, 1'b1, 1'b0, 1'b0, 2'b01);
    drv(1, 1'b1, 1'b0, 1'b1, 2'b10);
    @(negedge clk_i);
    drv(0, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("par_p0_issue", rf_idx_valid[0], 1'b1);
    chk("par_p1_issue", rf_idx_valid[1], 1'b1);
    chk("par_p1_rf_idx", rf_idx[1], 1);
    @(negedge clk_i); #1;
    chk("par_rr_hold", dut.rr_q, 0);
    chk("par_no_rsp0", rsp_valid[0], 1'b0);
    chk("par_no_rsp1", rsp_valid[1], 1'b0);
    chk("par_ready0", req_ready[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
